// File: rtl/vmx_buf_pkg.sv
// Shared types and constants for the VMX matrix-multiply local buffer.
package vmx_buf_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_RD_WIDTH   = 64;
    localparam int unsigned DEF_WR_WIDTH   = 128;
    localparam int unsigned DEF_HOST_WIDTH = 32;
    localparam int unsigned DEF_TIMEOUT    = 1024;

    localparam logic [31:0] ACC_CTRL_START = 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/vmx_buf_ram.sv
// Entry RAM: accelerator dual-entry write lane, host half-entry write lane,
// and two registered read ports (accelerator full entry, host half entry).
module vmx_buf_ram
    import vmx_buf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_RD_WIDTH,
    parameter int unsigned HALF_WIDTH = DEF_HOST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] acc_addr,
    input  logic                  acc_wr_en,
    input  logic [DATA_WIDTH-1:0] acc_wdata_lo,
    input  logic [DATA_WIDTH-1:0] acc_wdata_hi,
    output logic [DATA_WIDTH-1:0] acc_rdata,
    input  logic [ADDR_WIDTH:0]   host_addr,
    input  logic                  host_wr_en,
    input  logic                  host_rd_en,
    input  logic [HALF_WIDTH-1:0] host_wdata,
    output logic [HALF_WIDTH-1:0] host_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] acc_addr_p1;
    logic [ADDR_WIDTH-1:0] host_entry;
    logic                  host_half;

    assign acc_addr_p1 = acc_addr + ADDR_WIDTH'(1);
    assign host_entry  = host_addr[ADDR_WIDTH:1];
    assign host_half   = host_addr[0];

    // Accelerator lane is written last so it wins an entry collision with the host.
    always_ff @(posedge clk) begin
        if (host_wr_en) begin
            if (host_half) begin
                mem[host_entry][DATA_WIDTH-1:HALF_WIDTH] <= host_wdata;
            end else begin
                mem[host_entry][HALF_WIDTH-1:0] <= host_wdata;
            end
        end
        if (acc_wr_en) begin
            mem[acc_addr]    <= acc_wdata_lo;
            mem[acc_addr_p1] <= acc_wdata_hi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            acc_rdata <= mem[acc_addr];
            if (host_rd_en) begin
                host_rdata <= host_half ? mem[host_entry][DATA_WIDTH-1:HALF_WIDTH]
                                        : mem[host_entry][HALF_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/vmx_mm_buffer.sv
// Memory-side responder and run sequencer for the VMX matrix-multiply wrapper.
// Optional IRQ output enabled by defining VMX_BUF_IRQ_EN.
module vmx_mm_buffer
    import vmx_buf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned RD_WIDTH   = DEF_RD_WIDTH,
    parameter int unsigned WR_WIDTH   = DEF_WR_WIDTH,
    parameter int unsigned HOST_WIDTH = DEF_HOST_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] acc_addr,
    input  logic                  acc_wr_en,
    input  logic [WR_WIDTH-1:0]   acc_wdata,
    output logic [RD_WIDTH-1:0]   acc_rdata,
    output logic [31:0]           acc_ctrl,
    input  logic [31:0]           acc_flag,
    input  logic [ADDR_WIDTH:0]   host_addr,
    input  logic                  host_wr,
    input  logic                  host_rd,
    input  logic [HOST_WIDTH-1:0] host_wdata,
    output logic [HOST_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  host_ready,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
`ifdef VMX_BUF_IRQ_EN
    ,
    output logic                  irq,
    input  logic                  irq_clr
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             wd_expired;
    logic             timeout_err_d;
    logic [31:0]      acc_ctrl_d;
    logic             busy_d;
    logic             done_d;
    logic             host_wr_acc;
    logic             host_rd_acc;

    assign host_wr_acc = host_wr & host_ready;
    assign host_rd_acc = host_rd & ~host_wr & host_ready;
    assign wd_expired  = (wd_cnt_q == CNT_W'(TIMEOUT - 1));

    vmx_buf_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (RD_WIDTH),
        .HALF_WIDTH (HOST_WIDTH)
    ) u_ram (
        .clk          (clk),
        .rst_n        (rst_n),
        .acc_addr     (acc_addr),
        .acc_wr_en    (acc_wr_en),
        .acc_wdata_lo (acc_wdata[RD_WIDTH-1:0]),
        .acc_wdata_hi (acc_wdata[WR_WIDTH-1:RD_WIDTH]),
        .acc_rdata    (acc_rdata),
        .host_addr    (host_addr),
        .host_wr_en   (host_wr_acc),
        .host_rd_en   (host_rd_acc),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata)
    );

    // Next state and next registered outputs; watchdog runs through ARM and RUN.
    always_comb begin
        state_d       = state_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err;
        case (state_q)
            ST_IDLE: begin
                wd_cnt_d = '0;
                if (start) begin
                    state_d       = ST_ARM;
                    timeout_err_d = 1'b0;
                end
            end
            ST_ARM: begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
                if (wd_expired) begin
                    state_d       = ST_DONE;
                    timeout_err_d = 1'b1;
                end else if (acc_flag != '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
                if (acc_flag == '0) begin
                    state_d = ST_DONE;
                end else if (wd_expired) begin
                    state_d       = ST_DONE;
                    timeout_err_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        acc_ctrl_d = (state_d == ST_ARM) ? ACC_CTRL_START : '0;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wd_cnt_q    <= '0;
            acc_ctrl    <= '0;
            busy        <= 1'b0;
            host_ready  <= 1'b1;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_cnt_q    <= wd_cnt_d;
            acc_ctrl    <= acc_ctrl_d;
            busy        <= busy_d;
            host_ready  <= ~busy_d;
            done        <= done_d;
            timeout_err <= timeout_err_d;
            host_rvalid <= host_rd_acc;
        end
    end

`ifdef VMX_BUF_IRQ_EN
    // Set coincides with the done pulse and dominates a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (state_d == ST_DONE) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_vmx_mm_buffer.sv
// Directed self-checking bench for vmx_mm_buffer (host/accelerator RAM paths, run FSM, watchdog, reset).
module tb_vmx_mm_buffer;

    logic         clk;
    logic         rst_n;
    logic [7:0]   acc_addr;
    logic         acc_wr_en;
    logic [127:0] acc_wdata;
    logic [63:0]  acc_rdata;
    logic [31:0]  acc_ctrl;
    logic [31:0]  acc_flag;
    logic [8:0]   host_addr;
    logic         host_wr;
    logic         host_rd;
    logic [31:0]  host_wdata;
    logic [31:0]  host_rdata;
    logic         host_rvalid;
    logic         host_ready;
    logic         start;
    logic         busy;
    logic         done;
    logic         timeout_err;
`ifdef VMX_BUF_IRQ_EN
    logic         irq;
    logic         irq_clr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    vmx_mm_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .acc_addr    (acc_addr),
        .acc_wr_en   (acc_wr_en),
        .acc_wdata   (acc_wdata),
        .acc_rdata   (acc_rdata),
        .acc_ctrl    (acc_ctrl),
        .acc_flag    (acc_flag),
        .host_addr   (host_addr),
        .host_wr     (host_wr),
        .host_rd     (host_rd),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .host_ready  (host_ready),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
`ifdef VMX_BUF_IRQ_EN
        ,
        .irq         (irq),
        .irq_clr     (irq_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_watchdog: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int ctrl_hi;
        int n_done;
        int done_step;
        logic tmo_at_done;

        rst_n = 1'b1; acc_addr = '0; acc_wr_en = 1'b0; acc_wdata = '0; acc_flag = '0;
        host_addr = '0; host_wr = 1'b0; host_rd = 1'b0; host_wdata = '0; start = 1'b0;
`ifdef VMX_BUF_IRQ_EN
        irq_clr = 1'b0;
`endif
        #2 rst_n = 1'b0;
        tick(); tick();
        check("rst_acc_rdata", acc_rdata, 0);
        check("rst_acc_ctrl", acc_ctrl, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_rvalid", host_rvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_ready", host_ready, 1);
        rst_n = 1'b1;
        tick();

        // Host half writes into entry 5, read back on accelerator port
        host_wr = 1'b1; host_addr = 9'd10; host_wdata = 32'h1111_1111; tick();
        host_addr = 9'd11; host_wdata = 32'h2222_2222; tick();
        host_wr = 1'b0; acc_addr = 8'd5; tick();
        check("acc_rd_e5", acc_rdata, 64'h2222_2222_1111_1111);

        // Same-cycle accelerator write returns the old entry value
        acc_wr_en = 1'b1; acc_wdata = {64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD}; tick();
        check("acc_rd_prewrite", acc_rdata, 64'h2222_2222_1111_1111);
        acc_wr_en = 1'b0; tick();
        check("acc_rd_postwrite", acc_rdata, 64'hDDDD_DDDD_DDDD_DDDD);

        // Accelerator write at 255 wraps its upper half into entry 0
        acc_addr = 8'd255; acc_wr_en = 1'b1;
        acc_wdata = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB}; tick();
        acc_wr_en = 1'b0;
        check("rvalid_idle", host_rvalid, 0);
        host_rd = 1'b1; host_addr = 9'd510; tick();
        check("rv_e255_lo", host_rvalid, 1);
        check("rd_e255_lo", host_rdata, 32'hBBBB_BBBB);
        host_addr = 9'd511; tick();
        check("rd_e255_hi", host_rdata, 32'hBBBB_BBBB);
        host_addr = 9'd0; tick();
        check("rd_e0_lo", host_rdata, 32'hAAAA_AAAA);
        host_addr = 9'd1; tick();
        check("rv_e0_hi", host_rvalid, 1);
        check("rd_e0_hi", host_rdata, 32'hAAAA_AAAA);
        host_rd = 1'b0; tick();
        check("rv_drop", host_rvalid, 0);

        // Write and read together: write wins, no rvalid
        host_wr = 1'b1; host_rd = 1'b1; host_addr = 9'd2; host_wdata = 32'h1234_5678; tick();
        check("wr_rd_no_rvalid", host_rvalid, 0);
        host_wr = 1'b0; tick();
        check("wr_rd_rdata", host_rdata, 32'h1234_5678);
        host_rd = 1'b0;
        // Preload entry 3 low half for the busy-drop check
        host_wr = 1'b1; host_addr = 9'd6; host_wdata = 32'h3333_3333; tick();
        host_wr = 1'b0; tick();

        // Normal run: flag rises after 2 cycles in ARM, falls 20 cycles later; start held in DONE
        start = 1'b1; tick(); start = 1'b0;
        ctrl_hi = 0; n_done = 0; done_step = 0;
        for (int i = 1; i <= 40; i++) begin
            if (acc_ctrl == 32'd1) ctrl_hi++;
            if (done) begin n_done++; done_step = i; end
            if (i == 1) check("run_busy_arm", busy, 1);
            if (i == 3) check("run_ctrl_run", acc_ctrl, 0);
            if (i == 24) check("run_busy_after", busy, 0);
            if (i == 25) check("run_start_in_done", busy, 0);
            acc_flag = (i >= 2 && i < 22) ? 32'd1 : 32'd0;
            start = (i == 23);
            tick();
        end
        check("run_ctrl_cycles", 128'(ctrl_hi), 2);
        check("run_done_cnt", 128'(n_done), 1);
        check("run_done_step", 128'(done_step), 23);
        check("run_tmo", timeout_err, 0);
`ifdef VMX_BUF_IRQ_EN
        check("irq_set", irq, 1);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        check("irq_clr", irq, 0);
`endif

        // Stuck flag: watchdog fires after TIMEOUT cycles
        acc_flag = '0;
        start = 1'b1; tick(); start = 1'b0;
        ctrl_hi = 0; n_done = 0; done_step = 0; tmo_at_done = 1'b0;
        for (int i = 1; i <= 1040; i++) begin
            if (acc_ctrl == 32'd1) ctrl_hi++;
            if (done) begin n_done++; done_step = i; tmo_at_done = timeout_err; end
            if (i == 1024) check("tmo_early", timeout_err, 0);
            tick();
        end
        check("tmo_done_cnt", 128'(n_done), 1);
        check("tmo_done_step", 128'(done_step), 1025);
        check("tmo_flag_at_done", tmo_at_done, 1);
        check("tmo_ctrl_cycles", 128'(ctrl_hi), 1024);
        check("tmo_sticky", timeout_err, 1);
        check("tmo_busy_after", busy, 0);

        // Next start clears the error; host and start are ignored while busy
        start = 1'b1; tick();
        check("tmo_cleared", timeout_err, 0);
        check("busy_ready", host_ready, 0);
        host_wr = 1'b1; host_addr = 9'd6; host_wdata = 32'hDEAD_BEEF; tick();
        host_wr = 1'b0; host_rd = 1'b1; start = 1'b0; tick();
        check("busy_no_rvalid", host_rvalid, 0);
        host_rd = 1'b0; acc_flag = 32'd1; tick();
        check("run2_busy", busy, 1);
        check("run2_rvalid", host_rvalid, 0);

        // Reset during RUN
        rst_n = 1'b0; acc_flag = '0; tick();
        check("mid_rst_ctrl", acc_ctrl, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        rst_n = 1'b1; tick();
        check("post_rst_ready", host_ready, 1);
        host_rd = 1'b1; host_addr = 9'd6; tick();
        host_rd = 1'b0;
        check("busy_drop_rv", host_rvalid, 1);
        check("busy_drop_data", host_rdata, 32'h3333_3333);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vmx_mm_buffer.md
Name: vmx_mm_buffer

Overview:
- Memory-side responder for the VMX matrix-multiply wrapper's local buffer interface: serves its 64-bit reads, absorbs its 128-bit result writes, and drives its `ctrl` / observes its `flag`.
- Also exposes a 32-bit host port so the PS-side register/AXI-lite bridge can preload weights/vectors, launch a run and read back products.
- Sits between the host bridge and the VMX wrapper.

Parameters:
- ADDR_WIDTH, 8, accelerator word address width; buffer holds 2**ADDR_WIDTH 64-bit entries.
- RD_WIDTH, 64, accelerator read data width (one entry).
- WR_WIDTH, 128, accelerator write data width (two entries).
- HOST_WIDTH, 32, host data width (half an entry).
- TIMEOUT, 1024, max cycles allowed in RUN before error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- acc_addr  in  ADDR_WIDTH  accelerator entry address.
- acc_wr_en  in  1  accelerator write strobe.
- acc_wdata  in  WR_WIDTH  accelerator write data (its d_o).
- acc_rdata  out  RD_WIDTH  read data to accelerator (its d_i).
- acc_ctrl  out  32  start control to accelerator.
- acc_flag  in  32  accelerator state.
- host_addr  in  ADDR_WIDTH+1  host half-entry address; bit0 selects low/high 32 bits.
- host_wr  in  1  host write request.
- host_rd  in  1  host read request.
- host_wdata  in  HOST_WIDTH  host write data.
- host_rdata  out  HOST_WIDTH  host read data.
- host_rvalid  out  1  host read data valid.
- host_ready  out  1  host port accepts requests (= ~busy).
- start  in  1  launch request, sampled per cycle.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- timeout_err  out  1  sticky watchdog error; cleared by next accepted start.

Behaviour:
- Reset: state IDLE; acc_rdata, acc_ctrl, host_rdata, host_rvalid, busy, done and timeout_err all 0. Memory contents are not reset.
- Storage: 2**ADDR_WIDTH x 64-bit entries, single clock domain.
- Accelerator read:
  - acc_rdata <= mem[acc_addr] every cycle: 1-cycle registered latency, independent of state.
  - acc_rdata reflects the pre-write value on a same-cycle write to that address.
- Accelerator write (acc_wr_en = 1, accepted in every state):
  - mem[acc_addr] <= acc_wdata[63:0].
  - mem[acc_addr+1] <= acc_wdata[127:64].
  - addr+1 wraps modulo 2**ADDR_WIDTH (255 -> 0).
- Host port:
  - Requests are honoured only when host_ready = 1; requests made when host_ready = 0 are dropped with no side effect.
  - Write: updates half host_addr[0] of entry host_addr[ADDR_WIDTH:1]. The other half is untouched.
  - Read: host_rdata valid with host_rvalid = 1 exactly 1 cycle later.
  - host_wr and host_rd together: write wins, no rvalid.
- FSM:
  - IDLE: acc_ctrl = 0. On start, go to ARM, set busy, clear timeout_err.
  - ARM: acc_ctrl = 1. When acc_flag != 0, go to RUN.
  - RUN: acc_ctrl = 0; watchdog counts cycles. If acc_flag == 0, go to DONE. If the counter reaches TIMEOUT-1, set timeout_err and go to DONE.
  - DONE: done = 1 for one cycle, busy = 0 on exit, go to IDLE.
- start is ignored outside IDLE.
- The watchdog is also active in ARM, so an accelerator that never responds still terminates the run.
- busy is asserted from the cycle after start is accepted through the DONE cycle inclusive.
- Reset mid-run: immediate return to IDLE with acc_ctrl = 0; the accelerator is reset by the same rst_n.

Optional Feature:
- Macro VMX_BUF_IRQ_EN.
- Defined: adds ports irq (out, 1) and irq_clr (in, 1).
  - irq is set in the DONE cycle and held until irq_clr.
  - If irq_clr and a DONE set occur in the same cycle, set wins.
  - irq resets to 0.
- Undefined: ports absent; host polls busy/done.

Decomposition:
- Package vmx_buf_pkg:
  - state encoding constants ST_IDLE = 0, ST_ARM = 1, ST_RUN = 2, ST_DONE = 3.
  - ACC_CTRL_START = 32'd1.
  - default widths.
- One sub-module, vmx_buf_ram: 64-bit entry RAM with two write lanes (accelerator dual-entry write, host half-entry write) and two registered read ports.

Test Plan:
- Host writes 0x11111111 to half 0 and 0x22222222 to half 1 of entry 5; accelerator drives acc_addr = 5 -> acc_rdata = 0x22222222_11111111 one cycle later.
- Accelerator writes acc_addr = 255 with data {64'hAAAA.., 64'hBBBB..} -> entry 255 = BBBB.., entry 0 = AAAA..; verify via host reads, each with rvalid 1 cycle after its request.
- Pulse start; model accelerator flag 0->1 after 2 cycles, ->0 after 20 -> acc_ctrl = 1 exactly while in ARM, single done pulse, busy 0 afterwards, timeout_err 0.
- Pulse start with acc_flag stuck at 0 -> timeout_err = 1 after TIMEOUT cycles, done pulses once; next start clears timeout_err.
- While busy, host_wr to entry 3 -> memory unchanged, host_rvalid never asserted; a second start is ignored.
- Assert rst_n low during RUN -> next cycle acc_ctrl = 0, busy = 0, done = 0; with VMX_BUF_IRQ_EN defined, irq sets on done and clears on irq_clr.
